// File: rtl/led_blink_driver.sv
`default_nettype none
// ============================================================================
// Module  : led_blink_driver
// Brief   : Turns a one-cycle request into a timed, active-low LED blink train.
// Revision: 1.0 - initial release
// ============================================================================
module led_blink_driver #(
  parameter int CNT_W      = 16,
  parameter int ON_CYCLES  = 40000,
  parameter int OFF_CYCLES = 40000,
  parameter int BLINK_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BLINK_W-1:0] blinks,
  input  logic               cancel,
  output logic               LED,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0]   c_on_last  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_off_last = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_tmr_one  = CNT_W'(1);
  localparam logic [BLINK_W-1:0] c_blk_one  = BLINK_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_timer;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic [BLINK_W-1:0] r_remaining;
  logic [BLINK_W-1:0] w_remaining_nxt;
  logic               r_led;
  logic               r_busy;
  logic               r_done;
  logic               w_done_nxt;

  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cancel && (blinks != '0)) begin
          w_state_nxt     = S_ON;
          w_timer_nxt     = '0;
          w_remaining_nxt = blinks;
        end
      end
      S_ON: begin
        if (cancel) begin
          w_state_nxt     = S_IDLE;
          w_timer_nxt     = '0;
          w_remaining_nxt = '0;
        end else if (r_timer == c_on_last) begin
          w_timer_nxt = '0;
          // Final blink ends straight into IDLE; no trailing dark phase.
          if (r_remaining == c_blk_one) begin
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b1;
          end else begin
            w_state_nxt     = S_OFF;
            w_remaining_nxt = r_remaining - c_blk_one;
          end
        end else begin
          w_timer_nxt = r_timer + c_tmr_one;
        end
      end
      S_OFF: begin
        if (cancel) begin
          w_state_nxt     = S_IDLE;
          w_timer_nxt     = '0;
          w_remaining_nxt = '0;
        end else if (r_timer == c_off_last) begin
          w_state_nxt = S_ON;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + c_tmr_one;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_timer_nxt     = '0;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      r_led       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_remaining <= w_remaining_nxt;
      r_led       <= (w_state_nxt != S_ON);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  assign LED  = r_led;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_blink_driver
// Brief   : Directed self-checking bench for led_blink_driver (ON=4, OFF=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_blink_driver;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] blinks;
  logic       cancel;
  logic       LED;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  led_blink_driver #(
    .CNT_W     (16),
    .ON_CYCLES (4),
    .OFF_CYCLES(3),
    .BLINK_W   (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .blinks(blinks),
    .cancel(cancel),
    .LED   (LED),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_led, input logic e_busy, input logic e_done);
    chk({tag, ".LED"},  int'(LED),  int'(e_led));
    chk({tag, ".busy"}, int'(busy), int'(e_busy));
    chk({tag, ".done"}, int'(done), int'(e_done));
  endtask

  task automatic watch(input int ncyc, output int led_low, output int busy_c, output int done_c);
    led_low = 0;
    busy_c  = 0;
    done_c  = 0;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      if (LED  === 1'b0) led_low++;
      if (busy === 1'b1) busy_c++;
      if (done === 1'b1) done_c++;
    end
  endtask

  task automatic pulse_start(input logic [3:0] n);
    start  = 1'b1;
    blinks = n;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    logic [18:0] exp_led3;
    int lo, bz, dn;

    rst_n  = 1'b0;
    start  = 1'b1;
    blinks = 4'd3;
    cancel = 1'b0;

    // Reset held with start asserted
    tick();
    chk_out("rst1", 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("rst2", 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    watch(3, lo, bz, dn);
    chk_out("rst_rel", 1'b1, 1'b0, 1'b0);
    chk("rst_rel.busy_cnt", bz, 0);

    // Single blink: low T+1..T+4, done at T+5
    pulse_start(4'd1);
    chk_out("b1.k0", 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick();
    chk_out("b1.k3", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("b1.done", 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("b1.after", 1'b1, 1'b0, 1'b0);

    // Triple blink: 4 low / 3 high / 4 low / 3 high / 4 low, then done
    exp_led3 = 19'b1_0000_111_0000_111_0000;
    pulse_start(4'd3);
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("b3.LED[%0d]", k),  int'(LED),  int'(exp_led3[k]));
      chk($sformatf("b3.busy[%0d]", k), int'(busy), (k < 18) ? 1 : 0);
      chk($sformatf("b3.done[%0d]", k), int'(done), (k == 18) ? 1 : 0);
      tick();
    end
    chk_out("b3.after", 1'b1, 1'b0, 1'b0);

    // blinks=0 is ignored
    pulse_start(4'd0);
    chk_out("b0.next", 1'b1, 1'b0, 1'b0);
    watch(6, lo, bz, dn);
    chk("b0.busy_cnt", bz, 0);
    chk("b0.done_cnt", dn, 0);

    // Starts during a running blinks=2 sequence are ignored
    pulse_start(4'd2);
    lo = 1; bz = 1; dn = 0;
    for (int i = 1; i < 20; i++) begin
      if (i == 2 || i == 5 || i == 9) begin
        start  = 1'b1;
        blinks = 4'd5;
      end else begin
        start  = 1'b0;
      end
      tick();
      if (LED  === 1'b0) lo++;
      if (busy === 1'b1) bz++;
      if (done === 1'b1) dn++;
    end
    start = 1'b0;
    chk("b2.led_low_cnt", lo, 8);
    chk("b2.busy_cnt", bz, 11);
    chk("b2.done_cnt", dn, 1);

    // Cancel in the 2nd OFF phase of blinks=4 (k=11..13 is that OFF)
    pulse_start(4'd4);
    for (int i = 0; i < 12; i++) tick();
    chk_out("cx.k12", 1'b1, 1'b1, 1'b0);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk_out("cx.next", 1'b1, 1'b0, 1'b0);
    watch(20, lo, bz, dn);
    chk("cx.busy_cnt", bz, 0);
    chk("cx.done_cnt", dn, 0);

    // Cancel together with start in IDLE drops the request
    cancel = 1'b1;
    pulse_start(4'd3);
    cancel = 1'b0;
    chk_out("cs.next", 1'b1, 1'b0, 1'b0);
    watch(6, lo, bz, dn);
    chk("cs.busy_cnt", bz, 0);

    // Back-to-back: restart in the done cycle
    pulse_start(4'd1);
    tick(); tick(); tick(); tick();
    chk_out("bb.done1", 1'b1, 1'b0, 1'b1);
    pulse_start(4'd1);
    chk_out("bb.restart", 1'b0, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    chk_out("bb.done2", 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("bb.after", 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an ON phase
    pulse_start(4'd3);
    tick(); tick();
    chk_out("rm.k2", 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("rm.next", 1'b1, 1'b0, 1'b0);
    watch(25, lo, bz, dn);
    chk("rm.busy_cnt", bz, 0);
    chk("rm.done_cnt", dn, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
